fip_seq_div: RTL and testbench

//  Multi-cycle signed fixed-point divider (QI.F, two's complement) with valid/ready handshakes on both sides.

---
 rtl/fip_seq_div.sv | 197 +++++++++++++++++++
 tb/tb_fip_seq_div.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fip_seq_div.sv
// -----------------------------------------------------------------------------
// fip_seq_div -- multi-cycle signed fixed-point divider (QI.F, two's complement)
//
// Restoring radix-2 division on operand magnitudes, one quotient bit per clock.
// The result is truncated toward zero and re-signed on the final iteration.
// A request is taken when in_valid & in_ready; the result is offered with
// out_valid and held until out_ready.
//
// Parameters
//   WIDTH  total operand/result width in bits (>= 4)
//   FRAC   fractional bits (0 < FRAC < WIDTH); N = WIDTH+FRAC iterations
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      divider idle; request accepted when in_valid & in_ready
//   dividend   in   WIDTH  signed QI.F dividend, sampled on accept
//   divisor    in   WIDTH  signed QI.F divisor, sampled on accept
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result when out_valid & out_ready
//   quotient   out  WIDTH  signed QI.F result
//   overflow   out  1      true quotient outside the representable range
//   underflow  out  1      divide by zero
//
// Configuration
//   FIP_DIV_SATURATE_EN  when defined, overflowing results clamp to the most
//                        positive / most negative value and divide by zero
//                        returns a clamp chosen by the dividend sign. When not
//                        defined, overflow wraps and divide by zero returns 0.
// -----------------------------------------------------------------------------
module fip_seq_div #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow,
    output logic             underflow
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N);

    // Largest magnitudes that still fit the signed result, widened to N bits.
    localparam logic [N-1:0] MAG_MAX_POS = {{(FRAC + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [N-1:0] MAG_MAX_NEG = {{FRAC{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

`ifdef FIP_DIV_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    counter;
    logic             sign;       // result sign, msb(dividend) ^ msb(divisor)
    logic [N-1:0]     num;        // numerator bits, consumed MSB first
    logic [WIDTH-1:0] dvsr;       // |divisor|
    logic [WIDTH:0]   rem;        // partial remainder
    logic [N-2:0]     q;          // quotient magnitude bits gathered so far

    logic             accept;
    logic             div_zero;
    logic             last_step;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // -------------------------------------------------------------------------
    // Handshake and operand preparation
    // -------------------------------------------------------------------------
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign div_zero  = (divisor == '0);
    assign last_step = (counter == CW'(N - 1));

    // |-2^(WIDTH-1)| wraps back onto 2^(WIDTH-1), which is exactly right when
    // the bit pattern is read as unsigned.
    assign dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

    // -------------------------------------------------------------------------
    // One restoring step
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   dvsr_ext;
    logic             ge;
    logic [WIDTH:0]   rem_nx;
    logic [N-1:0]     q_nx;
    logic [N-1:0]     q_neg;
    logic             ovf_nx;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] dz_res;

    assign rem_sh   = {rem[WIDTH-1:0], num[N-1]};
    assign dvsr_ext = {1'b0, dvsr};
    // The remainder stays below the divisor, so rem[WIDTH] is always clear;
    // folding it in keeps the compare correct for the full shifted value.
    assign ge       = rem[WIDTH] | (rem_sh >= dvsr_ext);
    assign rem_nx   = ge ? (rem_sh - dvsr_ext) : rem_sh;
    assign q_nx     = {q, ge};
    assign q_neg    = ~q_nx + N'(1);

    // A negative result may reach one step further than a positive one.
    assign ovf_nx = sign ? (q_nx > MAG_MAX_NEG) : (q_nx > MAG_MAX_POS);

`ifdef FIP_DIV_SATURATE_EN
    assign res_nx = ovf_nx ? (sign ? SAT_NEG : SAT_POS)
                           : (sign ? q_neg[WIDTH-1:0] : q_nx[WIDTH-1:0]);
    assign dz_res = dividend[WIDTH-1] ? SAT_NEG : SAT_POS;
`else
    // -0 and +0 share one encoding, so a zero magnitude is always +0.
    assign res_nx = sign ? q_neg[WIDTH-1:0] : q_nx[WIDTH-1:0];
    assign dz_res = '0;
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: the default is assigned before the case so every path drives
    // state_nx; a missing path would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)    state_nx = div_zero ? DONE : CALC;
            CALC: if (last_step) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: the datapath registers are few flops, not a memory, so they share
    // the async reset; a reset mid-operation leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            sign      <= 1'b0;
            num       <= '0;
            dvsr      <= '0;
            rem       <= '0;
            q         <= '0;
            quotient  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (accept) begin
            counter <= '0;
            sign    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            num     <= {dvd_mag, {FRAC{1'b0}}};
            dvsr    <= dvs_mag;
            rem     <= '0;
            q       <= '0;
            if (div_zero) begin
                quotient  <= dz_res;
                overflow  <= 1'b0;
                underflow <= 1'b1;
            end
        end else if (state == CALC) begin
            counter <= counter + CW'(1);
            num     <= {num[N-2:0], 1'b0};
            rem     <= rem_nx;
            q       <= q_nx[N-2:0];
            if (last_step) begin
                quotient  <= res_nx;
                overflow  <= ovf_nx;
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fip_seq_div.sv
// -----------------------------------------------------------------------------
// tb_fip_seq_div -- self-checking bench for fip_seq_div at WIDTH=32, FRAC=16.
// Expected results come from a 64-bit integer model, are queued when a request
// is accepted and compared when the divider hands a result over.
// Honours FIP_DIV_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fip_seq_div;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int N     = WIDTH + FRAC;
    localparam int BOUND = 200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  dividend = '0;
    logic [WIDTH-1:0]  divisor = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  quotient;
    logic              overflow;
    logic              underflow;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             ovf;
        logic             udf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_res    = 0;

    fip_seq_div #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t   e;
        longint sa, sd, ma, md, qm, r;
        bit     s;
        e = '0;
        if (b == '0) begin
            e.udf = 1'b1;
`ifdef FIP_DIV_SATURATE_EN
            e.q = a[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            return e;
        end
        sa = longint'(signed'(a));
        sd = longint'(signed'(b));
        ma = (sa < 0) ? -sa : sa;
        md = (sd < 0) ? -sd : sd;
        qm = (ma << FRAC) / md;
        s  = a[WIDTH-1] ^ b[WIDTH-1];
        e.ovf = s ? (qm > 64'sd2147483648) : (qm > 64'sd2147483647);
        r   = s ? -qm : qm;
        e.q = r[WIDTH-1:0];
`ifdef FIP_DIV_SATURATE_EN
        if (e.ovf) e.q = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    // Result monitor: a result is consumed on the edge after a mid-cycle
    // sample that sees out_valid & out_ready.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected result", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("quotient #%0d", n_res), 64'(quotient), 64'(e.q));
                check($sformatf("overflow #%0d", n_res), 64'(overflow), 64'(e.ovf));
                check($sformatf("underflow #%0d", n_res), 64'(underflow), 64'(e.udf));
                n_res++;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit ok);
        int guard;
        guard    = 0;
        ok       = 1'b0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!ok && guard < BOUND) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (!ok) check("accept timeout", 64'd0, 64'd1);
        else     sb_q.push_back(model(a, b));
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("result timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok;
        int lat;
        out_ready = 1'b1;
        send(a, b, ok);
        if (ok) begin
            wait_valid(lat);
            check($sformatf("latency %h/%h", a, b), 64'(lat), (b == '0) ? 64'd0 : 64'(N));
            check("in_ready while done", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            check("in_ready after handshake", 64'(in_ready), 64'd1);
            check("out_valid after handshake", 64'(out_valid), 64'd0);
        end
    endtask

    logic [WIDTH-1:0] vec_a [10] = '{32'h0002_0000, 32'hFFFF_0000, 32'h0000_0002, 32'h0001_0000,
                                     32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000,
                                     32'hFFF8_0000, 32'h8000_0000};
    logic [WIDTH-1:0] vec_b [10] = '{32'h0002_0000, 32'h0000_8000, 32'h0000_0003, 32'h0000_0000,
                                     32'h0000_4000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0005,
                                     32'h0000_0000, 32'hFFFF_FFFF};

    initial begin : stim
        bit               ok;
        int               lat;
        logic [WIDTH-1:0] hold_q;
        logic             hold_o, hold_u;
        logic [WIDTH-1:0] ra, rb;

        // Reset values
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset underflow", 64'(underflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: basic, rounding, divide by zero, overflow, extremes
        for (int i = 0; i < 10; i++) run_op(vec_a[i], vec_b[i]);

        // Random operands with a nonzero divisor of varying magnitude
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 24);
            if (rb == '0) rb = 32'h0000_0001;
            run_op(ra, rb);
        end

        // Back-pressure: result held, busy requests ignored
        out_ready = 1'b0;
        send(32'h0003_0000, 32'hFFFF_8000, ok);
        if (ok) begin
            wait_valid(lat);
            hold_q = quotient;
            hold_o = overflow;
            hold_u = underflow;
            for (int i = 0; i < 10; i++) begin
                in_valid = i[0];
                dividend = $urandom;
                divisor  = $urandom;
                @(negedge clk);
                check($sformatf("held quotient %0d", i), 64'(quotient), 64'(hold_q));
                check($sformatf("held flags %0d", i), 64'({overflow, underflow}), 64'({hold_o, hold_u}));
                check($sformatf("held out_valid %0d", i), 64'(out_valid), 64'd1);
                check($sformatf("busy in_ready %0d", i), 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("in_ready after release", 64'(in_ready), 64'd1);
            check("out_valid after release", 64'(out_valid), 64'd0);
        end
        run_op(32'h0005_0000, 32'h0002_0000);

        // Reset in the middle of an iteration
        out_ready = 1'b1;
        send(32'h0001_0000, 32'h0003_0000, ok);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort quotient", 64'(quotient), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(32'h0000_8000, 32'h0000_4000);

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        check("results seen", 64'(n_res), 64'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
